// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared VGA timing types, default 640x480@60 timing and sync decode
//
// Purpose: default timing constants (the values every colour stage assumes),
//          the counter type and the registered sync bundle used by
//          vga_timing_gen and its interface.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_HPERIOD = 800;
  localparam int unsigned DEF_HFRONT  = 16;
  localparam int unsigned DEF_HWIDTH  = 96;
  localparam int unsigned DEF_HBACK   = 48;
  localparam int unsigned DEF_VPERIOD = 525;
  localparam int unsigned DEF_VFRONT  = 10;
  localparam int unsigned DEF_VWIDTH  = 2;
  localparam int unsigned DEF_VBACK   = 33;
  localparam int unsigned DEF_HBLANK  = DEF_HFRONT + DEF_HWIDTH + DEF_HBACK;
  localparam int unsigned DEF_VBLANK  = DEF_VFRONT + DEF_VWIDTH + DEF_VBACK;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs;  // active-low
    logic vs;  // active-low
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  // Sync ranges are [lo, hi); the active area starts at *_act.
  function automatic sync_t sync_decode(
    input cnt_t h,
    input cnt_t v,
    input cnt_t hs_lo,
    input cnt_t hs_hi,
    input cnt_t h_act,
    input cnt_t vs_lo,
    input cnt_t vs_hi,
    input cnt_t v_act
  );
    sync_t s;
    s.hs = !((h >= hs_lo) && (h < hs_hi));
    s.vs = !((v >= vs_lo) && (v < vs_hi));
    s.de = (h >= h_act) && (v >= v_act);
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing bundle from the VGA timing source to the pixel stages
//
// Signals: pck_en (pixel strobe), hcnt/vcnt (pixel/line counters),
//          vga_hs/vga_vs (active-low syncs), disp_en (visible area),
//          frame_start (one-cycle pulse after frame wrap).
// master: timing generator drives everything; slave: downstream stages read.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic pck_en;
  cnt_t hcnt;
  cnt_t vcnt;
  logic vga_hs;
  logic vga_vs;
  logic disp_en;
  logic frame_start;

  modport master (
    output pck_en, hcnt, vcnt, vga_hs, vga_vs, disp_en, frame_start
  );

  modport slave (
    input pck_en, hcnt, vcnt, vga_hs, vga_vs, disp_en, frame_start
  );

endinterface

// File: rtl/vga_pck_div.sv
// rtl/vga_pck_div.sv - pixel-clock enable divider
//
// Ports: clk, rst (sync, active-high), pck_en (one-cycle strobe every CLK_DIV cycles).
// pck_en is registered and is high exactly while the divider count sits at
// CLK_DIV-1; reset forces it low even when CLK_DIV=1.
module vga_pck_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pck_en
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;

  always_comb begin
    dcnt_nxt = (dcnt == D_LAST) ? '0 : dcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt   <= '0;
      pck_en <= 1'b0;
    end else begin
      dcnt   <= dcnt_nxt;
      pck_en <= (dcnt_nxt == D_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel strobe, h/v counters, syncs, display enable and frame pulse
//
// Ports: clk, rst (sync, active-high), vif (vga_timing_gen_if.master):
//        pck_en, hcnt, vcnt, vga_hs, vga_vs, disp_en, frame_start.
// Build option VGA_SYNC_DELAY_EN: vga_hs/vga_vs/disp_en get one extra
// pixel-stage register so they line up with stages that register RGB from hcnt.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned HPERIOD = DEF_HPERIOD,
  parameter int unsigned HFRONT  = DEF_HFRONT,
  parameter int unsigned HWIDTH  = DEF_HWIDTH,
  parameter int unsigned HBACK   = DEF_HBACK,
  parameter int unsigned VPERIOD = DEF_VPERIOD,
  parameter int unsigned VFRONT  = DEF_VFRONT,
  parameter int unsigned VWIDTH  = DEF_VWIDTH,
  parameter int unsigned VBACK   = DEF_VBACK
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vif
);

  localparam cnt_t H_LAST = cnt_t'(HPERIOD - 1);
  localparam cnt_t V_LAST = cnt_t'(VPERIOD - 1);
  localparam cnt_t HS_LO  = cnt_t'(HFRONT);
  localparam cnt_t HS_HI  = cnt_t'(HFRONT + HWIDTH);
  localparam cnt_t H_ACT  = cnt_t'(HFRONT + HWIDTH + HBACK);
  localparam cnt_t VS_LO  = cnt_t'(VFRONT);
  localparam cnt_t VS_HI  = cnt_t'(VFRONT + VWIDTH);
  localparam cnt_t V_ACT  = cnt_t'(VFRONT + VWIDTH + VBACK);

  logic  pck_en;
  cnt_t  hcnt;
  cnt_t  vcnt;
  cnt_t  hcnt_nxt;
  cnt_t  vcnt_nxt;
  logic  h_wrap;
  logic  v_wrap;
  logic  frame_start;
  sync_t sync_nxt;
  sync_t sync_r;
  sync_t sync_out;

  vga_pck_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pck_div (
    .clk    (clk),
    .rst    (rst),
    .pck_en (pck_en)
  );

  // Syncs are decoded from the next-state counters so they change on the
  // same edge as hcnt/vcnt rather than one pixel later.
  always_comb begin
    h_wrap   = (hcnt == H_LAST);
    v_wrap   = (vcnt == V_LAST);
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    if (pck_en) begin
      hcnt_nxt = h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) begin
        vcnt_nxt = v_wrap ? '0 : vcnt + 1'b1;
      end
    end
    sync_nxt = sync_decode(hcnt_nxt, vcnt_nxt, HS_LO, HS_HI, H_ACT,
                           VS_LO, VS_HI, V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      sync_r      <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      sync_r      <= sync_nxt;
      frame_start <= pck_en && h_wrap && v_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Captures the syncs of the pixel being left, so they trail hcnt/vcnt by one pixel.
  sync_t sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d <= SYNC_IDLE;
    end else if (pck_en) begin
      sync_d <= sync_r;
    end
  end

  assign sync_out = sync_d;
`else
  assign sync_out = sync_r;
`endif

  assign vif.pck_en      = pck_en;
  assign vif.hcnt        = hcnt;
  assign vif.vcnt        = vcnt;
  assign vif.vga_hs      = sync_out.hs;
  assign vif.vga_vs      = sync_out.vs;
  assign vif.disp_en     = sync_out.de;
  assign vif.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default and reduced timings)
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  // Reduced geometry so whole frames fit in a short run.
  localparam int S_HP = 40, S_HF = 3, S_HW = 5, S_HB = 4;
  localparam int S_VP = 20, S_VF = 2, S_VW = 2, S_VB = 3;

  typedef struct packed {
    logic       pck;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   e = 0;          // clock edges since the last reset edge
  logic started = 1'b0;
  logic phase1 = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen u_dut_a (
    .clk (clk),
    .rst (rst),
    .vif (if_a)
  );

  vga_timing_gen #(
    .CLK_DIV (2),
    .HPERIOD (S_HP), .HFRONT (S_HF), .HWIDTH (S_HW), .HBACK (S_HB),
    .VPERIOD (S_VP), .VFRONT (S_VF), .VWIDTH (S_VW), .VBACK (S_VB)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .vif (if_b)
  );

  vga_timing_gen #(
    .CLK_DIV (1),
    .HPERIOD (S_HP), .HFRONT (S_HF), .HWIDTH (S_HW), .HBACK (S_HB),
    .VPERIOD (S_VP), .VFRONT (S_VF), .VWIDTH (S_VW), .VBACK (S_VB)
  ) u_dut_c (
    .clk (clk),
    .rst (rst),
    .vif (if_c)
  );

  always @(posedge clk) begin
    if (rst) begin
      e       <= 0;
      started <= 1'b1;
    end else begin
      e <= e + 1;
    end
  end

  // Expected outputs after n edges since reset, from the timing rules:
  // the strobe is high when n mod D == D-1, the pixel index is the number of
  // strobes seen before the edge, and the counters are that index split into
  // line/column.
  function automatic exp_t model(input int d, input int hp, input int hf, input int hw,
                                 input int hb, input int vp, input int vf, input int vw,
                                 input int vb, input int n);
    exp_t x;
    int   p, q, hq, vq;
    logic adv;
    x = '0;
    x.hs = 1'b1;
    x.vs = 1'b1;
    if (n == 0) return x;
    x.pck = ((n % d) == (d - 1));
    p     = n / d - ((d == 1) ? 1 : 0);
    adv   = (n >= 2) && (((n - 1) % d) == (d - 1));
    x.h   = 10'(p % hp);
    x.v   = 10'((p / hp) % vp);
    x.fs  = adv && (p % (hp * vp) == 0);
`ifdef VGA_SYNC_DELAY_EN
    if (p == 0) return x;
    q = p - 1;
`else
    q = p;
`endif
    hq   = q % hp;
    vq   = (q / hp) % vp;
    x.hs = !((hq >= hf) && (hq < hf + hw));
    x.vs = !((vq >= vf) && (vq < vf + vw));
    x.de = (hq >= hf + hw + hb) && (vq >= vf + vw + vb);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string n, input logic pck, input logic [9:0] h, input logic [9:0] v,
                     input logic hs, input logic vs, input logic de, input logic fs,
                     input exp_t x);
    chk({n, ".pck_en"}, 32'(pck), 32'(x.pck));
    chk({n, ".hcnt"}, 32'(h), 32'(x.h));
    chk({n, ".vcnt"}, 32'(v), 32'(x.v));
    chk({n, ".vga_hs"}, 32'(hs), 32'(x.hs));
    chk({n, ".vga_vs"}, 32'(vs), 32'(x.vs));
    chk({n, ".disp_en"}, 32'(de), 32'(x.de));
    chk({n, ".frame_start"}, 32'(fs), 32'(x.fs));
  endtask

  // Single compare process: every cycle, every instance, against the model.
  always @(negedge clk) begin
    if (started) begin
      cmp("A", if_a.pck_en, if_a.hcnt, if_a.vcnt, if_a.vga_hs, if_a.vga_vs,
          if_a.disp_en, if_a.frame_start,
          model(DEF_CLK_DIV, DEF_HPERIOD, DEF_HFRONT, DEF_HWIDTH, DEF_HBACK,
                DEF_VPERIOD, DEF_VFRONT, DEF_VWIDTH, DEF_VBACK, e));
      cmp("B", if_b.pck_en, if_b.hcnt, if_b.vcnt, if_b.vga_hs, if_b.vga_vs,
          if_b.disp_en, if_b.frame_start,
          model(2, S_HP, S_HF, S_HW, S_HB, S_VP, S_VF, S_VW, S_VB, e));
      cmp("C", if_c.pck_en, if_c.hcnt, if_c.vcnt, if_c.vga_hs, if_c.vga_vs,
          if_c.disp_en, if_c.frame_start,
          model(1, S_HP, S_HF, S_HW, S_HB, S_VP, S_VF, S_VW, S_VB, e));
    end
  end

  // Statistics for the hand-computed literal expectations of the first run.
  int a_first_pck = -1;
  int a_hs_cyc = 0, a_hs_min = 9999, a_hs_max = -1;
  int a_prev_h = 0, a_prev_v = 0;
  int a_wrap_seen = 0, a_wrap_pv = -1, a_wrap_v = -1;
  int b_fs = 0, b_last = 0, b_int_bad = 0, b_de = 0;
  int c_fs = 0, c_last = 0, c_int_bad = 0, c_de = 0;

  always @(negedge clk) begin
    if (phase1) begin
      if (if_a.pck_en && a_first_pck < 0) a_first_pck = e + 1;
      if (!if_a.vga_hs && if_a.vcnt == 0) begin
        a_hs_cyc++;
        if (int'(if_a.hcnt) < a_hs_min) a_hs_min = int'(if_a.hcnt);
        if (int'(if_a.hcnt) > a_hs_max) a_hs_max = int'(if_a.hcnt);
      end
      if (a_wrap_seen == 0 && a_prev_h == 799 && if_a.hcnt == 0) begin
        a_wrap_seen = 1;
        a_wrap_pv   = a_prev_v;
        a_wrap_v    = int'(if_a.vcnt);
      end
      a_prev_h = int'(if_a.hcnt);
      a_prev_v = int'(if_a.vcnt);
      if (if_b.disp_en && b_fs == 1) b_de++;
      if (if_b.frame_start) begin
        if (b_fs > 0 && (e - b_last) != 1600) b_int_bad++;
        b_last = e;
        b_fs++;
      end
      if (if_c.disp_en && c_fs == 1) c_de++;
      if (if_c.frame_start) begin
        if (c_fs > 0 && (e - c_last) != 800) c_int_bad++;
        c_last = e;
        c_fs++;
      end
    end
  end

  initial begin
    logic found;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    phase1 = 1'b1;
    repeat (6500) @(negedge clk);
    phase1 = 1'b0;

    chk("a_first_pck_cycle", 32'(a_first_pck), 32'd4);
    chk("a_hs_low_cycles_line0", 32'(a_hs_cyc), 32'd384);
`ifdef VGA_SYNC_DELAY_EN
    chk("a_hs_first_hcnt", 32'(a_hs_min), 32'd17);
    chk("a_hs_last_hcnt", 32'(a_hs_max), 32'd112);
`else
    chk("a_hs_first_hcnt", 32'(a_hs_min), 32'd16);
    chk("a_hs_last_hcnt", 32'(a_hs_max), 32'd111);
`endif
    chk("a_line_wrap_seen", 32'(a_wrap_seen), 32'd1);
    chk("a_wrap_vcnt_before", 32'(a_wrap_pv), 32'd0);
    chk("a_wrap_vcnt_after", 32'(a_wrap_v), 32'd1);
    chk("b_frame_pulses", 32'(b_fs), 32'd4);
    chk("b_frame_interval_bad", 32'(b_int_bad), 32'd0);
    chk("b_disp_en_cycles_frame", 32'(b_de), 32'd728);
    chk("c_frame_pulses", 32'(c_fs), 32'd8);
    chk("c_frame_interval_bad", 32'(c_int_bad), 32'd0);
    chk("c_disp_en_cycles_frame", 32'(c_de), 32'd364);

    // Random run lengths with random mid-frame resets.
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(200, 2500)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end

    // Reset at a known mid-frame position of instance B.
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk);
      if (if_b.hcnt == 10'd20 && if_b.vcnt == 10'd10) found = 1'b1;
    end
    chk("b_mid_position_reached", 32'(found), 32'd1);
    if (found) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("b_mid_reset_hcnt", 32'(if_b.hcnt), 32'd0);
      chk("b_mid_reset_vcnt", 32'(if_b.vcnt), 32'd0);
      chk("b_mid_reset_hs", 32'(if_b.vga_hs), 32'd1);
      chk("b_mid_reset_vs", 32'(if_b.vga_vs), 32'd1);
      chk("b_mid_reset_frame_start", 32'(if_b.frame_start), 32'd0);
      chk("b_mid_reset_pck_en", 32'(if_b.pck_en), 32'd0);
    end
    repeat (2000) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
